// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer between a UART RX controller and a consumer.
// Each entry stores the received byte together with its framing-error tag.
// The byte is written on rx_done_pulse. Reads have a fixed latency of one cycle.
// Two sticky flags are kept: overrun (a byte was dropped) and frame_err (a framing error was seen).
// irq is a registered level: high when the fill level reaches IRQ_THRESH or overrun is set.
// Storage is addressed by wrapping pointers, so DEPTH must be a power of two and at least 2.
// IRQ_THRESH must lie in the range 1..DEPTH.
//
// Read handshake: the consumer raises rd_en to request one entry per cycle.
// A request while empty=1 is dropped; there is no back-pressure.
// An accepted request produces exactly one rd_valid strobe on the following cycle.
// rd_data/rd_err are only meaningful while rd_valid=1, and hold their value between pops.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 8
) (
    input  logic                    clk_16mhz,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_done_pulse,
    input  logic                    rx_error,
    input  logic                    rd_en,
    input  logic                    clr_flags,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_err,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overrun,
    output logic                    frame_err,
    output logic                    irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] IRQ_LVL  = CW'(IRQ_THRESH);

    // Entry layout: {error tag, data byte}
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          pop_ok;
    logic          push_ok;
    logic          drop;
    logic [CW-1:0] count_nxt;
    logic          overrun_nxt;
    logic          frame_err_nxt;

    // Accept/drop decisions and next occupancy/flag values.
    // A full FIFO still takes a byte if a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok        = rd_en && !empty;
        push_ok       = rx_done_pulse && (!full || rd_en);
        drop          = rx_done_pulse && full && !rd_en;
        count_nxt     = count;
        overrun_nxt   = overrun;
        frame_err_nxt = frame_err;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        // Set events take priority over a same-cycle clear
        if (drop)
            overrun_nxt = 1'b1;
        else if (clr_flags)
            overrun_nxt = 1'b0;
        if (rx_error)
            frame_err_nxt = 1'b1;
        else if (clr_flags)
            frame_err_nxt = 1'b0;
    end

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk_16mhz) begin
        if (!rst && push_ok)
            mem[wr_ptr] <= {rx_error, rx_data};
    end

    // Pointers, status, sticky flags and the registered read port.
    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr][DATA_WIDTH-1:0];
                rd_err  <= mem[rd_ptr][DATA_WIDTH];
            end
            rd_valid  <= pop_ok;
            count     <= count_nxt;
            empty     <= (count_nxt == '0);
            full      <= (count_nxt == FULL_LVL);
            overrun   <= overrun_nxt;
            frame_err <= frame_err_nxt;
            irq       <= (count_nxt >= IRQ_LVL) || overrun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random scenarios for uart_rx_fifo.
// Expected entries are pushed to exp_q when a byte is driven and accepted.
// They are popped and compared when the DUT returns them.
module tb_uart_rx_fifo;

    logic       clk_16mhz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done_pulse = 1'b0;
    logic       rx_error = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       frame_err;
    logic       irq;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .IRQ_THRESH(8)) dut (
        .clk_16mhz(clk_16mhz), .rst(rst), .rx_data(rx_data), .rx_done_pulse(rx_done_pulse),
        .rx_error(rx_error), .rd_en(rd_en), .clr_flags(clr_flags), .rd_data(rd_data),
        .rd_err(rd_err), .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .frame_err(frame_err), .irq(irq)
    );

    // Clock and counters
    always #31 clk_16mhz = ~clk_16mhz;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard and reference model state
    logic [8:0] exp_q[$];
    int         m_cnt = 0;
    logic       m_over = 1'b0;
    logic       m_ferr = 1'b0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = '0;
    logic       exp_err = 1'b0;

    // Advance one edge and settle past it
    task automatic tick();
        @(posedge clk_16mhz);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        exp_q.delete();
        m_cnt = 0; m_over = 1'b0; m_ferr = 1'b0;
        exp_valid = 1'b0; exp_data = '0; exp_err = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus and update the model for that edge
    task automatic drive_cycle(input logic push, input logic [7:0] d, input logic e,
                               input logic rd, input logic clr);
        logic       pop_ok;
        logic       push_ok;
        logic [8:0] v;
        pop_ok  = rd && (m_cnt > 0);
        push_ok = push && ((m_cnt < 16) || rd);
        rx_done_pulse = push; rx_data = d; rx_error = e; rd_en = rd; clr_flags = clr;
        exp_valid = pop_ok;
        if (pop_ok) begin
            v = exp_q.pop_front();
            exp_data = v[7:0];
            exp_err  = v[8];
        end
        if (push_ok) exp_q.push_back({e, d});
        m_cnt = m_cnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
        if (push && !push_ok) m_over = 1'b1;
        else if (clr) m_over = 1'b0;
        if (e) m_ferr = 1'b1;
        else if (clr) m_ferr = 1'b0;
        tick();
        rx_done_pulse = 1'b0; rx_error = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if ({empty, full} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full got %b want 10", {empty, full}); end
        n_checks++; if ({rd_valid, rd_err, rd_data} !== 10'd0) begin n_fail++; $display("FAIL reset_read_port got %b/%b/%h want 0/0/00", rd_valid, rd_err, rd_data); end
        n_checks++; if ({overrun, frame_err, irq} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {overrun, frame_err, irq}); end
    endtask

    task automatic test_basic();
        drive_cycle(1, 8'hA5, 0, 0, 0);
        drive_cycle(1, 8'h3C, 0, 0, 0);
        n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL basic_count got %0d want 2", count); end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(0, 0, 0, 1, 0);
            n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want 1", i, rd_valid); end
            n_checks++; if ({rd_err, rd_data} !== {exp_err, exp_data}) begin n_fail++; $display("FAIL basic_data[%0d] got %b/%h want %b/%h", i, rd_err, rd_data, exp_err, exp_data); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
        drive_cycle(0, 0, 0, 0, 0);
        n_checks++; if ({rd_valid, rd_data} !== {1'b0, 8'h3C}) begin n_fail++; $display("FAIL basic_hold got %b/%h want 0/3c", rd_valid, rd_data); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 17; i++) begin
            drive_cycle(1, 8'(i), 0, 0, 0);
            if (i == 15) begin
                n_checks++; if ({full, count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL ovr_full got %b/%0d want 1/16", full, count); end
                n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b want 0", overrun); end
            end
        end
        n_checks++; if ({overrun, count, irq} !== {1'b1, 5'd16, 1'b1}) begin n_fail++; $display("FAIL ovr_set got %b/%0d/%b want 1/16/1", overrun, count, irq); end
        for (int i = 0; i < 16; i++) begin
            drive_cycle(0, 0, 0, 1, 0);
            n_checks++; if ({rd_valid, rd_data} !== {1'b1, exp_data}) begin n_fail++; $display("FAIL ovr_drain[%0d] got %b/%h want 1/%h", i, rd_valid, rd_data, exp_data); end
        end
        n_checks++; if ({empty, exp_data} !== {1'b1, 8'h0F}) begin n_fail++; $display("FAIL ovr_last got %b/%h want 1/0f", empty, exp_data); end
        drive_cycle(0, 0, 0, 0, 1);
        n_checks++; if ({overrun, irq} !== 2'b00) begin n_fail++; $display("FAIL ovr_clear got %b want 00", {overrun, irq}); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) drive_cycle(1, 8'h20 + 8'(i), 0, 0, 0);
        drive_cycle(1, 8'h77, 0, 1, 0);
        n_checks++; if ({count, overrun} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL fpp_state got %0d/%b want 16/0", count, overrun); end
        n_checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h20}) begin n_fail++; $display("FAIL fpp_first got %b/%h want 1/20", rd_valid, rd_data); end
        for (int i = 0; i < 16; i++) begin
            drive_cycle(0, 0, 0, 1, 0);
            n_checks++; if ({rd_valid, rd_data} !== {1'b1, exp_data}) begin n_fail++; $display("FAIL fpp_drain[%0d] got %b/%h want 1/%h", i, rd_valid, rd_data, exp_data); end
        end
        n_checks++; if ({empty, rd_data} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL fpp_last got %b/%h want 1/77", empty, rd_data); end
    endtask

    task automatic test_frame_err();
        drive_cycle(1, 8'h55, 1, 0, 0);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b want 1", frame_err); end
        drive_cycle(0, 0, 0, 1, 0);
        n_checks++; if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b1, 8'h55}) begin n_fail++; $display("FAIL ferr_pop got %b/%b/%h want 1/1/55", rd_valid, rd_err, rd_data); end
        drive_cycle(0, 0, 0, 0, 1);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b want 0", frame_err); end
        // Error without a frame strobe still sets the flag, and beats a same-cycle clear
        drive_cycle(0, 8'hEE, 1, 0, 1);
        n_checks++; if ({frame_err, count} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL ferr_win got %b/%0d want 1/0", frame_err, count); end
        drive_cycle(0, 0, 0, 0, 1);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear2 got %b want 0", frame_err); end
    endtask

    task automatic test_irq();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1, 8'h40 + 8'(i), 0, 0, 0);
            if (i == 6) begin
                n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_below got %b want 0", irq); end
            end
        end
        n_checks++; if ({irq, count} !== {1'b1, 5'd8}) begin n_fail++; $display("FAIL irq_rise got %b/%0d want 1/8", irq, count); end
        drive_cycle(0, 0, 0, 1, 0);
        n_checks++; if ({irq, rd_data} !== {1'b0, 8'h40}) begin n_fail++; $display("FAIL irq_fall got %b/%h want 0/40", irq, rd_data); end
        while (m_cnt > 0) drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_empty_push_pop();
        drive_cycle(1, 8'hC3, 0, 1, 0);
        n_checks++; if ({rd_valid, count} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL epp_nofall got %b/%0d want 0/1", rd_valid, count); end
        drive_cycle(0, 0, 0, 1, 0);
        n_checks++; if ({rd_valid, rd_data, empty} !== {1'b1, 8'hC3, 1'b1}) begin n_fail++; $display("FAIL epp_pop got %b/%h/%b want 1/c3/1", rd_valid, rd_data, empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_cycle(1, 8'h60 + 8'(i), 0, 0, 0);
        // Stimulus during reset must be ignored
        rx_done_pulse = 1'b1; rx_data = 8'hFF; rd_en = 1'b1;
        do_reset(1);
        rx_done_pulse = 1'b0; rd_en = 1'b0;
        n_checks++; if ({count, empty, rd_valid} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rst_mid got %0d/%b/%b want 0/1/0", count, empty, rd_valid); end
        drive_cycle(1, 8'h9E, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0);
        n_checks++; if ({rd_valid, rd_data, count} !== {1'b1, 8'h9E, 5'd0}) begin n_fail++; $display("FAIL rst_first got %b/%h/%0d want 1/9e/0", rd_valid, rd_data, count); end
        drive_cycle(0, 0, 0, 1, 0);
        n_checks++; if ({rd_valid, rd_data} !== {1'b0, 8'h9E}) begin n_fail++; $display("FAIL rst_rd_empty got %b/%h want 0/9e", rd_valid, rd_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0),
                        ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            n_checks++; if ({rd_valid, rd_err, rd_data} !== {exp_valid, exp_err, exp_data}) begin n_fail++; $display("FAIL rnd_read[%0d] got %b/%b/%h want %b/%b/%h", i, rd_valid, rd_err, rd_data, exp_valid, exp_err, exp_data); end
            n_checks++; if ({count, empty, full} !== {m_cnt[4:0], m_cnt == 0, m_cnt == 16}) begin n_fail++; $display("FAIL rnd_status[%0d] got %0d/%b/%b want %0d", i, count, empty, full, m_cnt); end
            n_checks++; if ({overrun, frame_err, irq} !== {m_over, m_ferr, (m_cnt >= 8) || m_over}) begin n_fail++; $display("FAIL rnd_flags[%0d] got %b%b%b want %b%b", i, overrun, frame_err, irq, m_over, m_ferr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_push_pop();
        test_frame_err();
        test_irq();
        test_empty_push_pop();
        test_reset_mid();
        do_reset(1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
